// File: rtl/note_pkg.sv
// Shared note encodings, LED patterns and period windows for the tone generator
// and the note detector.
package note_pkg;

    typedef enum logic [1:0] {
        NOTE_NONE = 2'd0,
        NOTE_C    = 2'd1,
        NOTE_D    = 2'd2,
        NOTE_E    = 2'd3
    } note_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } det_state_t;

    localparam logic [7:0] LED_NONE = 8'b00000000;
    localparam logic [7:0] LED_C    = 8'b00000100;
    localparam logic [7:0] LED_D    = 8'b00000010;
    localparam logic [7:0] LED_E    = 8'b00000001;

    // Inclusive period windows in samples at 48 kHz
    localparam logic [7:0] E_MIN = 8'd69;
    localparam logic [7:0] E_MAX = 8'd77;
    localparam logic [7:0] D_MIN = 8'd78;
    localparam logic [7:0] D_MAX = 8'd86;
    localparam logic [7:0] C_MIN = 8'd87;
    localparam logic [7:0] C_MAX = 8'd96;

    function automatic note_t classify(input logic [7:0] p);
        if (p >= E_MIN && p <= E_MAX) return NOTE_E;
        if (p >= D_MIN && p <= D_MAX) return NOTE_D;
        if (p >= C_MIN && p <= C_MAX) return NOTE_C;
        return NOTE_NONE;
    endfunction

    function automatic logic [7:0] leds_of(input note_t n);
        case (n)
            NOTE_C:  return LED_C;
            NOTE_D:  return LED_D;
            NOTE_E:  return LED_E;
            default: return LED_NONE;
        endcase
    endfunction

endpackage

// File: rtl/note_detector_zcd.sv
// Schmitt-trigger sign tracker producing a one-cycle pulse on each rising
// crossing of an accepted sample.
module zero_cross_detector #(
    parameter int                  SAMPLE_W = 24,
    parameter logic [SAMPLE_W-1:0] HYST     = 24'h0800
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear_i,
    input  logic                strobe_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    output logic                rise_o
);

    localparam logic signed [SAMPLE_W-1:0] THR_POS = $signed(HYST);
    localparam logic signed [SAMPLE_W-1:0] THR_NEG = -THR_POS;

    logic signed [SAMPLE_W-1:0] sample_s;
    logic                       above;
    logic                       below;
    logic                       pos_q;
    logic                       pos_d;

    assign sample_s = $signed(sample_i);
    assign above    = sample_s > THR_POS;
    assign below    = sample_s < THR_NEG;

    always_comb begin
        pos_d = pos_q;
        if (clear_i)
            pos_d = 1'b0;
        else if (strobe_i && above)
            pos_d = 1'b1;
        else if (strobe_i && below)
            pos_d = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            pos_q <= 1'b0;
        else
            pos_q <= pos_d;
    end

    assign rise_o = strobe_i && !clear_i && !pos_q && above;

endmodule

// File: rtl/note_detector.sv
// Pops codec ADC samples, measures the period between rising crossings and locks
// onto C5/D5/E5 after LOCK_COUNT consistent periods.
module note_detector
    import note_pkg::*;
#(
    parameter int                  SAMPLE_W   = 24,
    parameter logic [SAMPLE_W-1:0] HYST       = 24'h0800,
    parameter int                  LOCK_COUNT = 4,
    parameter int                  TIMEOUT    = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                read_ready,
    input  logic [SAMPLE_W-1:0] readdata_left,
    output logic                read,
    output logic [1:0]          note_id,
    output logic                note_valid,
    output logic [7:0]          note_leds,
    output logic [7:0]          period
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [3:0] LOCK_C    = 4'(LOCK_COUNT);

    logic       read_q, read_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] period_q, period_d;
    logic [3:0] match_q, match_d;
    note_t      cand_q, cand_d;
    note_t      note_q, note_d;
    logic       valid_q, valid_d;
    det_state_t state_q, state_d;

    logic       accept;
    logic       crossing;
    logic       timeout;
    logic       lock_hit;
    logic [7:0] cnt_inc;
    note_t      cls;

    assign accept  = read_q && enable;
    assign cnt_inc = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
    assign cls     = classify(cnt_inc);
    // A crossing on the same sample always takes priority over silence
    assign timeout = accept && !crossing && (cnt_inc >= TIMEOUT_C);

    zero_cross_detector #(
        .SAMPLE_W (SAMPLE_W),
        .HYST     (HYST)
    ) u_zcd (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (!enable),
        .strobe_i (accept),
        .sample_i (readdata_left),
        .rise_o   (crossing)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_q   <= 1'b0;
            cnt_q    <= 8'd0;
            period_q <= 8'd0;
            match_q  <= 4'd0;
            cand_q   <= NOTE_NONE;
            note_q   <= NOTE_NONE;
            valid_q  <= 1'b0;
            state_q  <= ST_IDLE;
        end else begin
            read_q   <= read_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            match_q  <= match_d;
            cand_q   <= cand_d;
            note_q   <= note_d;
            valid_q  <= valid_d;
            state_q  <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable)
            state_d = ST_IDLE;
        else if (crossing) begin
            if (state_q == ST_IDLE)
                state_d = ST_TRACK;
            else if (lock_hit)
                state_d = (cand_d != NOTE_NONE) ? ST_LOCKED : ST_TRACK;
        end else if (timeout)
            state_d = ST_IDLE;
    end

    always_comb begin
        read_d   = enable && read_ready && !read_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        match_d  = match_q;
        cand_d   = cand_q;
        note_d   = note_q;
        valid_d  = valid_q;
        lock_hit = 1'b0;
        if (!enable) begin
            cnt_d    = 8'd0;
            period_d = 8'd0;
            match_d  = 4'd0;
            cand_d   = NOTE_NONE;
            note_d   = NOTE_NONE;
            valid_d  = 1'b0;
        end else if (crossing) begin
            cnt_d    = 8'd0;
            period_d = cnt_inc;
            if (state_q == ST_IDLE) begin
                match_d = 4'd0;
                cand_d  = NOTE_NONE;
            end else begin
                if (cls == cand_q)
                    match_d = (match_q >= LOCK_C) ? match_q : match_q + 4'd1;
                else begin
                    cand_d  = cls;
                    match_d = 4'd1;
                end
                // A NONE candidate reaching the count clears the outputs
                if (match_d == LOCK_C) begin
                    lock_hit = 1'b1;
                    note_d   = cand_d;
                    valid_d  = (cand_d != NOTE_NONE);
                end
            end
        end else if (accept) begin
            cnt_d = cnt_inc;
            if (timeout) begin
                match_d = 4'd0;
                note_d  = NOTE_NONE;
                valid_d = 1'b0;
            end
        end
    end

    assign read       = read_q;
    assign note_id    = note_q;
    assign note_valid = valid_q;
    assign note_leds  = leds_of(note_q);
    assign period     = period_q;

endmodule
